// File: rtl/writeback_stage_pkg.sv
// Shared types and defaults for the write-back stage and its register file.
package writeback_stage_pkg;

    localparam int unsigned XLEN_DEF         = 64;
    localparam int unsigned CNT_W_DEF        = 64;
    localparam int unsigned FLUSH_CYCLES_DEF = 3;
    localparam logic [4:0]  REG_ZERO         = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_e;

    // Flush timer load value; the timer counts down to zero, so N cycles load N-1.
    function automatic logic [3:0] flush_load(int unsigned cycles);
        return 4'(cycles - 1);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Registered result bundle handed from the memory-access stage to write-back.
interface writeback_stage_if #(
    parameter int unsigned XLEN = writeback_stage_pkg::XLEN_DEF
);
    logic            EN;
    logic [4:0]      rd_i;
    logic [XLEN-1:0] res_i;
    logic            wb_en_i;
    logic            take_branch_i;
    logic [XLEN-1:0] branch_offset_i;
    logic [XLEN-1:0] PC_i;

    modport master (
        output EN, rd_i, res_i, wb_en_i, take_branch_i, branch_offset_i, PC_i
    );

    modport slave (
        input  EN, rd_i, res_i, wb_en_i, take_branch_i, branch_offset_i, PC_i
    );
endinterface

// File: rtl/writeback_stage_regfile.sv
// 32 x XLEN integer register file: one synchronous write, two asynchronous
// reads with same-cycle write bypass, x0 hardwired to zero.
module regfile_2r1w
    import writeback_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    // x0 has no storage; index 0 is never read or written.
    logic [XLEN-1:0] regs [1:31];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != REG_ZERO) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 == REG_ZERO) begin
            rdata1 = '0;
        end else if (we && waddr == raddr1) begin
            rdata1 = wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 == REG_ZERO) begin
            rdata2 = '0;
        end else if (we && waddr == raddr2) begin
            rdata2 = wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits results, bypasses reads to decode, and turns a
// taken branch into a one-cycle redirect plus a timed upstream flush.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal operation; commits, retires and accepts branches
// ST_FLUSH | post-branch squash; flush timer counting down, inputs ignored
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    writeback_stage_if.slave mem,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [3:0] FLUSH_LOAD = flush_load(FLUSH_CYCLES);

    wb_state_e       state_q, state_d;
    logic [3:0]      flush_cnt_q, flush_cnt_d;
    logic            redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_d;
    logic            flush_d;
    logic            commit;

    assign commit = mem.wb_en_i && (mem.rd_i != REG_ZERO) && (state_q == ST_RUN);

    regfile_2r1w #(
        .XLEN (XLEN)
    ) u_regfile (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .we     (commit),
        .waddr  (mem.rd_i),
        .wdata  (mem.res_i),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q        <= ST_RUN;
            flush_cnt_q    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush          <= flush_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc;
        flush_d          = flush;

        unique case (state_q)
            ST_RUN: begin
                if (mem.take_branch_i) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mem.PC_i + mem.branch_offset_i;
                    flush_d          = 1'b1;
                    flush_cnt_d      = FLUSH_LOAD;
                    // A single-cycle flush needs no timer, so stay in RUN.
                    state_d          = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
                end else begin
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                flush_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fwd_rd     <= REG_ZERO;
            fwd_data   <= '0;
            retire_cnt <= '0;
        end else begin
            if (commit) begin
                fwd_rd   <= mem.rd_i;
                fwd_data <= mem.res_i;
            end else begin
                fwd_rd   <= REG_ZERO;
            end
            if (mem.EN && state_q == ST_RUN) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for commit/bypass, then
// hand-written branch, flush, wrap and reset sequences.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        flush;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic [63:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    writeback_stage_if #(.XLEN(64)) mem_if ();

    writeback_stage #(
        .XLEN         (64),
        .FLUSH_CYCLES (3),
        .CNT_W        (64)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .mem            (mem_if),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .retire_cnt     (retire_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        en;
        logic        wb;
        logic [4:0]  rd;
        logic [63:0] res;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [63:0] e1;
        logic [63:0] e2;
        logic [4:0]  efr;
        logic [63:0] efd;
        logic [63:0] eret;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic en, input logic wb, input logic [4:0] rd,
                         input logic [63:0] res, input logic tb,
                         input logic [63:0] pc, input logic [63:0] off);
        mem_if.EN              = en;
        mem_if.wb_en_i         = wb;
        mem_if.rd_i            = rd;
        mem_if.res_i           = res;
        mem_if.take_branch_i   = tb;
        mem_if.PC_i            = pc;
        mem_if.branch_offset_i = off;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected values computed by hand from an all-zero register file.
        vecs[0] = '{1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd0,
                    64'hDEAD_BEEF, 64'h0, 5'd5, 64'hDEAD_BEEF, 64'd1};
        vecs[1] = '{1'b1, 1'b0, 5'd0, 64'h0, 5'd5, 5'd5,
                    64'hDEAD_BEEF, 64'hDEAD_BEEF, 5'd0, 64'hDEAD_BEEF, 64'd2};
        vecs[2] = '{1'b1, 1'b1, 5'd0, 64'h1234, 5'd0, 5'd5,
                    64'h0, 64'hDEAD_BEEF, 5'd0, 64'hDEAD_BEEF, 64'd3};
        vecs[3] = '{1'b0, 1'b1, 5'd3, 64'h3333, 5'd3, 5'd5,
                    64'h3333, 64'hDEAD_BEEF, 5'd3, 64'h3333, 64'd3};
        vecs[4] = '{1'b1, 1'b1, 5'd5, 64'h5555, 5'd5, 5'd3,
                    64'h5555, 64'h3333, 5'd5, 64'h5555, 64'd4};
        vecs[5] = '{1'b1, 1'b0, 5'd5, 64'hFFFF, 5'd5, 5'd3,
                    64'h5555, 64'h3333, 5'd0, 64'h5555, 64'd5};

        RST_N    = 1'b0;
        rs1_addr = 5'd5;
        rs2_addr = 5'd1;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 64'h0);
        tick();
        tick();
        chk("reset_redirect_valid", 64'(redirect_valid), 64'h0);
        chk("reset_flush", 64'(flush), 64'h0);
        chk("reset_fwd_rd", 64'(fwd_rd), 64'h0);
        chk("reset_retire", retire_cnt, 64'h0);
        chk("reset_rs1", rs1_data, 64'h0);
        RST_N = 1'b1;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].en, vecs[i].wb, vecs[i].rd, vecs[i].res, 1'b0, 64'h0, 64'h0);
            rs1_addr = vecs[i].a1;
            rs2_addr = vecs[i].a2;
            #1;
            chk($sformatf("vec%0d_rs1", i), rs1_data, vecs[i].e1);
            chk($sformatf("vec%0d_rs2", i), rs2_data, vecs[i].e2);
            tick();
            chk($sformatf("vec%0d_fwd_rd", i), 64'(fwd_rd), 64'(vecs[i].efr));
            chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].efd);
            chk($sformatf("vec%0d_retire", i), retire_cnt, vecs[i].eret);
            chk($sformatf("vec%0d_flush", i), 64'(flush), 64'h0);
        end

        // Taken branch; write to x7 during the flush must be dropped.
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0);
        tick();
        chk("br_redirect_valid", 64'(redirect_valid), 64'h1);
        chk("br_redirect_pc", redirect_pc, 64'h0FF0);
        chk("br_flush_c1", 64'(flush), 64'h1);
        chk("br_retire", retire_cnt, 64'd6);
        drive(1'b1, 1'b1, 5'd7, 64'h7777, 1'b0, 64'h0, 64'h0);
        rs1_addr = 5'd7;
        #1;
        chk("br_no_bypass_in_flush", rs1_data, 64'h0);
        tick();
        chk("br_redirect_pulse", 64'(redirect_valid), 64'h0);
        chk("br_flush_c2", 64'(flush), 64'h1);
        chk("br_fwd_rd_flush", 64'(fwd_rd), 64'h0);
        tick();
        chk("br_flush_c3", 64'(flush), 64'h1);
        tick();
        chk("br_flush_end", 64'(flush), 64'h0);
        chk("br_retire_frozen", retire_cnt, 64'd6);
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 64'h0);
        #1;
        chk("br_x7_unchanged", rs1_data, 64'h0);

        // Branch with same-cycle write and PC wrap; branches held during flush.
        drive(1'b1, 1'b1, 5'd1, 64'd42, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd16);
        rs1_addr = 5'd1;
        #1;
        chk("wrap_bypass_x1", rs1_data, 64'd42);
        tick();
        chk("wrap_redirect_valid", 64'(redirect_valid), 64'h1);
        chk("wrap_redirect_pc", redirect_pc, 64'h8);
        chk("wrap_fwd_rd", 64'(fwd_rd), 64'd1);
        chk("wrap_fwd_data", fwd_data, 64'd42);
        chk("wrap_retire", retire_cnt, 64'd7);
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 64'h0, 64'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("flushbr_no_redirect_%0d", i), 64'(redirect_valid), 64'h0);
            chk($sformatf("flushbr_pc_hold_%0d", i), redirect_pc, 64'h8);
        end
        chk("flushbr_flush_end", 64'(flush), 64'h0);
        chk("flushbr_retire", retire_cnt, 64'd7);
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 64'h0);
        #1;
        chk("wrap_x1_committed", rs1_data, 64'd42);

        // Reset in the second flush cycle.
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 64'h2000, 64'd8);
        tick();
        chk("rst_br_pc", redirect_pc, 64'h2008);
        chk("rst_br_retire", retire_cnt, 64'd8);
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 64'h0);
        tick();
        chk("rst_flush_c2", 64'(flush), 64'h1);
        RST_N    = 1'b0;
        rs1_addr = 5'd5;
        rs2_addr = 5'd1;
        tick();
        chk("rst_flush", 64'(flush), 64'h0);
        chk("rst_redirect_valid", 64'(redirect_valid), 64'h0);
        chk("rst_redirect_pc", redirect_pc, 64'h0);
        chk("rst_retire", retire_cnt, 64'h0);
        chk("rst_fwd_data", fwd_data, 64'h0);
        chk("rst_rs1_x5", rs1_data, 64'h0);
        chk("rst_rs2_x1", rs2_data, 64'h0);
        RST_N = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 64'h100, 64'd4);
        tick();
        chk("post_rst_redirect_valid", 64'(redirect_valid), 64'h1);
        chk("post_rst_redirect_pc", redirect_pc, 64'h104);
        chk("post_rst_flush", 64'(flush), 64'h1);
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 64'h0, 64'h0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
